// File: rtl/cdc_toggle_rx_mc_pkg.sv
// cdc_pkg: shared constants, channel FSM encoding and helpers for the
// multi-channel toggle-handshake CDC receiver.
package cdc_pkg;

  // Smallest synchroniser depth that still gives a metastability settling stage.
  localparam int SYNC_STAGES_MIN = 2;

  // Default configuration widths.
  localparam int DATAWIDTH_DEF   = 8;
  localparam int NUM_CH_DEF      = 2;
  localparam int SYNC_STAGES_DEF = 2;

  // Width of the optional per-channel overrun counter.
  localparam int OVR_CNT_W = 8;

  // Per-channel holding-register state; FULL is exactly dest_valid=1.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ch_state_e;

  // Saturating increment for the overrun counter (holds at all-ones).
  function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
    logic [OVR_CNT_W-1:0] r;
    if (v == {OVR_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(OVR_CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/cdc_toggle_rx_mc_sync_bit.sv
// cdc_sync_bit: single-bit multi-flop synchroniser with asynchronous
// active-high reset. Input is treated as fully asynchronous to CLK.
module cdc_sync_bit
  import cdc_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  // Depth is never allowed below the minimum settling chain.
  localparam int STAGES_L = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

  logic [STAGES_L-1:0] sync_r;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_r <= {STAGES_L{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES_L-2:0], d};
    end
  end

  assign q = sync_r[STAGES_L-1];

endmodule

// File: rtl/cdc_toggle_rx_mc.sv
// cdc_toggle_rx_mc: destination-domain receiver of a multi-channel
// toggle-handshake CDC. Each channel synchronises its load toggle, captures
// the quasi-static source word on a toggle edge, offers it on valid/ready,
// returns an ack toggle per consumed word and flags overruns.
// Optional build macro: CDC_RX_OVR_CNT_EN adds per-channel saturating
// overrun counters on port ovr_cnt.
module cdc_toggle_rx_mc
  import cdc_pkg::*;
#(
  parameter int DATAWIDTH   = DATAWIDTH_DEF,
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_CH-1:0]             src_load_tgl,
  input  logic [NUM_CH*DATAWIDTH-1:0]   src_data,
  output logic [NUM_CH-1:0]             dest_valid,
  input  logic [NUM_CH-1:0]             dest_ready,
  output logic [NUM_CH*DATAWIDTH-1:0]   dest_data,
  output logic [NUM_CH-1:0]             dest_ack_tgl,
  output logic [NUM_CH-1:0]             ovr_err,
`ifdef CDC_RX_OVR_CNT_EN
  output logic [NUM_CH*OVR_CNT_W-1:0]   ovr_cnt,
`endif
  input  logic [NUM_CH-1:0]             ovr_clr
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch

    logic                 sync_s;
    logic                 prev_r;
    logic                 ld_s;
    ch_state_e            state_r;
    ch_state_e            state_nxt_s;
    logic                 cap_s;
    logic                 ack_flip_s;
    logic                 ovr_set_s;
    logic [DATAWIDTH-1:0] data_r;
    logic                 ack_r;
    logic                 ovr_r;

    cdc_sync_bit #(
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .CLK (CLK),
      .RST (RST),
      .d   (src_load_tgl[c]),
      .q   (sync_s)
    );

    // Delay the synchronised toggle so either edge yields a one-cycle load pulse.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        prev_r <= 1'b0;
      end else begin
        prev_r <= sync_s;
      end
    end

    assign ld_s = sync_s ^ prev_r;

    // Channel state register.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        state_r <= ST_EMPTY;
      end else begin
        state_r <= state_nxt_s;
      end
    end

    // Next-state and datapath control: capture, consume/ack, overrun detect.
    always_comb begin
      state_nxt_s = state_r;
      cap_s       = 1'b0;
      ack_flip_s  = 1'b0;
      ovr_set_s   = 1'b0;
      case (state_r)
        ST_EMPTY: begin
          if (ld_s) begin
            cap_s       = 1'b1;
            state_nxt_s = ST_FULL;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (dest_ready[c]) begin
            // Old word consumed; a coincident load refills without a bubble.
            ack_flip_s = 1'b1;
            if (ld_s) begin
              cap_s       = 1'b1;
              state_nxt_s = ST_FULL;
            end else begin
              state_nxt_s = ST_EMPTY;
            end
          end else if (ld_s) begin
            // Holding register busy: new word is dropped, not acknowledged.
            ovr_set_s   = 1'b1;
            state_nxt_s = ST_FULL;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end

    // Capture register; holds the last word when no load is accepted.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        data_r <= {DATAWIDTH{1'b0}};
      end else if (cap_s) begin
        data_r <= src_data[c*DATAWIDTH +: DATAWIDTH];
      end else begin
        data_r <= data_r;
      end
    end

    // Ack toggle back to the source, one flip per consumed word.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        ack_r <= 1'b0;
      end else if (ack_flip_s) begin
        ack_r <= ~ack_r;
      end else begin
        ack_r <= ack_r;
      end
    end

    // Sticky overrun flag; a coincident set beats the clear.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        ovr_r <= 1'b0;
      end else if (ovr_set_s) begin
        ovr_r <= 1'b1;
      end else if (ovr_clr[c]) begin
        ovr_r <= 1'b0;
      end else begin
        ovr_r <= ovr_r;
      end
    end

`ifdef CDC_RX_OVR_CNT_EN
    logic [OVR_CNT_W-1:0] cnt_r;

    // Saturating dropped-word counter; clear plus overrun restarts at one.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        cnt_r <= {OVR_CNT_W{1'b0}};
      end else if (ovr_clr[c] && ovr_set_s) begin
        cnt_r <= {{(OVR_CNT_W-1){1'b0}}, 1'b1};
      end else if (ovr_clr[c]) begin
        cnt_r <= {OVR_CNT_W{1'b0}};
      end else if (ovr_set_s) begin
        cnt_r <= sat_inc(cnt_r);
      end else begin
        cnt_r <= cnt_r;
      end
    end

    assign ovr_cnt[c*OVR_CNT_W +: OVR_CNT_W] = cnt_r;
`endif

    assign dest_valid[c]                       = (state_r == ST_FULL);
    assign dest_data[c*DATAWIDTH +: DATAWIDTH] = data_r;
    assign dest_ack_tgl[c]                     = ack_r;
    assign ovr_err[c]                          = ovr_r;

  end : g_ch

endmodule

// File: tb/tb_cdc_toggle_rx_mc.sv
// Self-checking bench for cdc_toggle_rx_mc (NUM_CH=4, DATAWIDTH=8, SYNC_STAGES=2).
// Expected words are queued per channel when a toggle is driven and popped
// when the DUT presents them. Optional counter checks under CDC_RX_OVR_CNT_EN.
module tb_cdc_toggle_rx_mc;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int SS = 2;

  logic            CLK;
  logic            RST;
  logic [NC-1:0]   src_load_tgl;
  logic [NC*DW-1:0] src_data;
  logic [NC-1:0]   dest_valid;
  logic [NC-1:0]   dest_ready;
  logic [NC*DW-1:0] dest_data;
  logic [NC-1:0]   dest_ack_tgl;
  logic [NC-1:0]   ovr_err;
  logic [NC-1:0]   ovr_clr;
`ifdef CDC_RX_OVR_CNT_EN
  logic [NC*8-1:0] ovr_cnt;
`endif

  int checks;
  int errors;
  logic [NC-1:0] exp_ack;
  logic [DW-1:0] sb_q [NC][$];

  cdc_toggle_rx_mc #(
    .DATAWIDTH   (DW),
    .NUM_CH      (NC),
    .SYNC_STAGES (SS)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .src_load_tgl (src_load_tgl),
    .src_data     (src_data),
    .dest_valid   (dest_valid),
    .dest_ready   (dest_ready),
    .dest_data    (dest_data),
    .dest_ack_tgl (dest_ack_tgl),
    .ovr_err      (ovr_err),
`ifdef CDC_RX_OVR_CNT_EN
    .ovr_cnt      (ovr_cnt),
`endif
    .ovr_clr      (ovr_clr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive a new word and flip the channel toggle; queue it if it should arrive.
  task automatic send(input int c, input logic [DW-1:0] d, input bit deliver);
    src_data[c*DW +: DW] = d;
    src_load_tgl[c]      = ~src_load_tgl[c];
    if (deliver) sb_q[c].push_back(d);
  endtask

  task automatic wait_valid(input int c);
    int n;
    n = 0;
    while (!dest_valid[c] && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (dest_valid[c] !== 1'b1) begin
      $display("FAIL wait_valid ch%0d: dest_valid=%b after %0d cycles, required 1", c, dest_valid[c], n);
      errors++;
    end
  endtask

  // Compare the presented word against the scoreboard head (pop if consuming).
  task automatic check_word(input int c, input bit pop, input string tag);
    logic [DW-1:0] e;
    checks++;
    if (sb_q[c].size() == 0) begin
      $display("FAIL %s ch%0d: scoreboard empty, dest_data=%h", tag, c, dest_data[c*DW +: DW]);
      errors++;
    end else begin
      e = pop ? sb_q[c].pop_front() : sb_q[c][0];
      if (dest_data[c*DW +: DW] !== e) begin
        $display("FAIL %s ch%0d: dest_data=%h, required %h", tag, c, dest_data[c*DW +: DW], e);
        errors++;
      end
    end
  endtask

  task automatic check_bit(input string tag, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      $display("FAIL %s: got %b, required %b", tag, act, req);
      errors++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    src_load_tgl = '0;
    src_data     = $urandom;
    dest_ready   = 4'($urandom_range(0, 15));
    ovr_clr      = 4'($urandom_range(0, 15));
    repeat (3) tick();
    checks++;
    if (dest_valid !== 4'h0 || dest_data !== 32'h0 || dest_ack_tgl !== 4'h0 || ovr_err !== 4'h0) begin
      $display("FAIL reset_outputs: valid=%h data=%h ack=%h ovr=%h, required all 0",
               dest_valid, dest_data, dest_ack_tgl, ovr_err);
      errors++;
    end
`ifdef CDC_RX_OVR_CNT_EN
    checks++;
    if (ovr_cnt !== 32'h0) begin
      $display("FAIL reset_ovr_cnt: got %h, required 0", ovr_cnt);
      errors++;
    end
`endif
    dest_ready = '0;
    ovr_clr    = '0;
    RST        = 1'b0;
    exp_ack    = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_bit("idle_no_valid", |dest_valid, 1'b0);
    end
  endtask

  task automatic test_basic();
    dest_ready[0] = 1'b1;
    send(0, 8'hA5, 1'b1);
    tick();
    tick();
    check_bit("basic_latency_early", dest_valid[0], 1'b0);
    tick();
    check_bit("basic_latency_valid", dest_valid[0], 1'b1);
    check_bit("basic_no_early_ack", dest_ack_tgl[0], exp_ack[0]);
    check_word(0, 1'b1, "basic_data");
    exp_ack[0] = ~exp_ack[0];
    tick();
    check_bit("basic_valid_drop", dest_valid[0], 1'b0);
    check_bit("basic_ack", dest_ack_tgl[0], exp_ack[0]);
    dest_ready[0] = 1'b0;
  endtask

  task automatic test_backpressure();
    send(0, 8'h3C, 1'b1);
    wait_valid(0);
    for (int i = 0; i < 10; i++) begin
      check_word(0, 1'b0, "bp_hold");
      check_bit("bp_valid_hold", dest_valid[0], 1'b1);
      check_bit("bp_no_ack", dest_ack_tgl[0], exp_ack[0]);
      tick();
    end
    check_word(0, 1'b1, "bp_data");
    dest_ready[0] = 1'b1;
    exp_ack[0] = ~exp_ack[0];
    tick();
    dest_ready[0] = 1'b0;
    check_bit("bp_valid_drop", dest_valid[0], 1'b0);
    repeat (3) begin
      check_bit("bp_single_ack", dest_ack_tgl[0], exp_ack[0]);
      tick();
    end
  endtask

  task automatic test_back_to_back();
    send(0, 8'h11, 1'b1);
    wait_valid(0);
    send(0, 8'h22, 1'b1);
    tick();
    tick();
    check_word(0, 1'b1, "b2b_old");
    dest_ready[0] = 1'b1;
    exp_ack[0] = ~exp_ack[0];
    tick();
    check_bit("b2b_no_bubble", dest_valid[0], 1'b1);
    check_word(0, 1'b1, "b2b_new");
    check_bit("b2b_ack_once", dest_ack_tgl[0], exp_ack[0]);
    check_bit("b2b_no_ovr", ovr_err[0], 1'b0);
    exp_ack[0] = ~exp_ack[0];
    tick();
    dest_ready[0] = 1'b0;
    check_bit("b2b_drain", dest_valid[0], 1'b0);
    check_bit("b2b_ack2", dest_ack_tgl[0], exp_ack[0]);
  endtask

  task automatic test_overrun();
    send(0, 8'h55, 1'b1);
    wait_valid(0);
    send(0, 8'h66, 1'b0);
    repeat (4) tick();
    check_word(0, 1'b0, "ovr_keep_old");
    check_bit("ovr_err_set", ovr_err[0], 1'b1);
    check_bit("ovr_no_ack", dest_ack_tgl[0], exp_ack[0]);
`ifdef CDC_RX_OVR_CNT_EN
    checks++;
    if (ovr_cnt[7:0] !== 8'd1) begin
      $display("FAIL ovr_cnt_one: got %0d, required 1", ovr_cnt[7:0]);
      errors++;
    end
`endif
    for (int i = 0; i < 300; i++) begin
      send(0, 8'(i), 1'b0);
      tick();
    end
    repeat (4) tick();
    check_word(0, 1'b0, "ovr_keep_old_burst");
    check_bit("ovr_err_sticky", ovr_err[0], 1'b1);
`ifdef CDC_RX_OVR_CNT_EN
    checks++;
    if (ovr_cnt[7:0] !== 8'd255) begin
      $display("FAIL ovr_cnt_sat: got %0d, required 255", ovr_cnt[7:0]);
      errors++;
    end
`endif
    ovr_clr[0] = 1'b1;
    tick();
    ovr_clr[0] = 1'b0;
    check_bit("ovr_clr", ovr_err[0], 1'b0);
`ifdef CDC_RX_OVR_CNT_EN
    checks++;
    if (ovr_cnt[7:0] !== 8'd0) begin
      $display("FAIL ovr_cnt_clr: got %0d, required 0", ovr_cnt[7:0]);
      errors++;
    end
`endif
    send(0, 8'h77, 1'b0);
    tick();
    tick();
    ovr_clr[0] = 1'b1;
    tick();
    ovr_clr[0] = 1'b0;
    check_bit("ovr_set_wins", ovr_err[0], 1'b1);
`ifdef CDC_RX_OVR_CNT_EN
    checks++;
    if (ovr_cnt[7:0] !== 8'd1) begin
      $display("FAIL ovr_cnt_set_clr: got %0d, required 1", ovr_cnt[7:0]);
      errors++;
    end
`endif
    ovr_clr[0] = 1'b1;
    tick();
    ovr_clr[0] = 1'b0;
    check_word(0, 1'b1, "ovr_consume");
    dest_ready[0] = 1'b1;
    exp_ack[0] = ~exp_ack[0];
    tick();
    dest_ready[0] = 1'b0;
    check_bit("ovr_drain", dest_valid[0], 1'b0);
    check_bit("ovr_ack", dest_ack_tgl[0], exp_ack[0]);
    checks++;
    if (dest_data[7:0] !== 8'h55) begin
      $display("FAIL data_hold_after_consume: got %h, required 55", dest_data[7:0]);
      errors++;
    end
  endtask

  task automatic test_channels_reset();
    send(1, 8'h91, 1'b1);
    tick();
    send(2, 8'hA2, 1'b1);
    tick();
    send(3, 8'hB3, 1'b1);
    repeat (4) tick();
    check_bit("ind_ch0_empty", dest_valid[0], 1'b0);
    for (int c = 1; c < NC; c++) begin
      check_bit("ind_valid", dest_valid[c], 1'b1);
      check_word(c, 1'b0, "ind_data");
    end
    check_word(1, 1'b1, "ind_pop1");
    dest_ready[1] = 1'b1;
    exp_ack[1] = ~exp_ack[1];
    tick();
    dest_ready[1] = 1'b0;
    check_word(3, 1'b1, "ind_pop3");
    dest_ready[3] = 1'b1;
    exp_ack[3] = ~exp_ack[3];
    tick();
    dest_ready[3] = 1'b0;
    checks++;
    if (dest_ack_tgl !== exp_ack || dest_valid !== 4'b0100) begin
      $display("FAIL ind_acks: ack=%b valid=%b, required ack=%b valid=0100",
               dest_ack_tgl, dest_valid, exp_ack);
      errors++;
    end
    check_word(2, 1'b0, "ind_ch2_full");
    dest_ready[2] = 1'b1;
    RST = 1'b1;
    #2;
    checks++;
    if (dest_valid !== 4'h0 || dest_data !== 32'h0 || dest_ack_tgl !== 4'h0 || ovr_err !== 4'h0) begin
      $display("FAIL midreset_outputs: valid=%h data=%h ack=%h ovr=%h, required all 0",
               dest_valid, dest_data, dest_ack_tgl, ovr_err);
      errors++;
    end
    src_load_tgl = '0;
    sb_q[2].delete();
    exp_ack = '0;
    tick();
    tick();
    RST = 1'b0;
    repeat (5) begin
      tick();
      checks++;
      if (dest_valid !== 4'h0 || dest_ack_tgl !== 4'h0) begin
        $display("FAIL post_reset_idle: valid=%b ack=%b, required 0 0", dest_valid, dest_ack_tgl);
        errors++;
      end
    end
    dest_ready = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_channels_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
